// File: rtl/mips_reg_write_arbiter_pkg.sv
// Shared constants, types and helpers for the register-file write-port arbiter.
// These constants match the ones the register file uses, so both sides
// agree on the address and data widths.
package mips_reg_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int GRANT_ID_W = 2;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // One writeback as it is latched toward the register file.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  // Round-robin successor of a granted index, wrapping at num_req-1.
  function automatic logic [GRANT_ID_W-1:0] rr_next(
    input logic [GRANT_ID_W-1:0] idx,
    input int                    num_req
  );
    if (int'(idx) >= num_req - 1) return '0;
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/mips_reg_write_arbiter_if.sv
// Bundle of the writeback request bus and the register-file write port.
// The requester side (master) drives requests and watches the write port;
// the arbiter (slave) answers with ready and drives the write port.
interface mips_reg_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
);
  import mips_reg_write_arbiter_pkg::*;

  logic                           wr_enable;
  logic [NUM_REQ-1:0]             req_valid;
  logic [REG_ADDR_W*NUM_REQ-1:0]  req_reg;
  logic [DATA_W*NUM_REQ-1:0]      req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [REG_ADDR_W-1:0]          write_reg;
  logic [DATA_W-1:0]              write_data;
  logic                           signal_reg_write;
  logic [GRANT_ID_W-1:0]          grant_id;
  logic [CNT_W-1:0]               write_count;

  modport master (
    output wr_enable, req_valid, req_reg, req_data,
    input  req_ready, write_reg, write_data, signal_reg_write, grant_id, write_count
  );

  modport slave (
    input  wr_enable, req_valid, req_reg, req_data,
    output req_ready, write_reg, write_data, signal_reg_write, grant_id, write_count
  );

endinterface

// File: rtl/mips_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// the pointer, wrapping around. The pointer itself lives in the parent.
module mips_rr_arbiter
  import mips_reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  enable,
  input  logic [GRANT_ID_W-1:0] ptr,
  output logic [NUM_REQ-1:0]    grant,
  output logic [GRANT_ID_W-1:0] grant_idx,
  output logic                  grant_valid
);

  // Walk the requesters in priority order starting at ptr; first hit wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!grant_valid && req[i] && (i == ((int'(ptr) + k) % NUM_REQ))) begin
            grant_valid = 1'b1;
            grant[i]    = 1'b1;
            grant_idx   = GRANT_ID_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/mips_reg_write_arbiter.sv
// Shares the single register-file write port among NUM_REQ writeback sources.
// One request is accepted per cycle in round-robin order; the winner is
// registered and presented to the register file on the following cycle.
// Writes to $zero are accepted but never strobed or counted.
module mips_reg_write_arbiter
  import mips_reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input logic                     clk,
  input logic                     reset,
  mips_reg_write_arbiter_if.slave bus
);

  logic [GRANT_ID_W-1:0] rr_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [GRANT_ID_W-1:0] grant_idx;
  logic                  grant_valid;
  wb_req_t               sel_req;
  wb_req_t               wb_q;
  logic                  strobe_q;
  logic [GRANT_ID_W-1:0] grant_id_q;
  logic [CNT_W-1:0]      count_q;

  // Holding off grants while reset is high keeps req_ready at zero then.
  mips_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req         (bus.req_valid),
    .enable      (bus.wr_enable & ~reset),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Steer the granted requester's register and data toward the output stage.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_req.reg_addr = bus.req_reg[REG_ADDR_W*i +: REG_ADDR_W];
        sel_req.data     = bus.req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Latch the winner, advance the pointer, and raise the strobe for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      wb_q       <= '0;
      strobe_q   <= 1'b0;
      grant_id_q <= '0;
    end else if (grant_valid) begin
      rr_ptr     <= rr_next(grant_idx, NUM_REQ);
      wb_q       <= sel_req;
      strobe_q   <= (sel_req.reg_addr != ZERO_REG);
      grant_id_q <= grant_idx;
    end else begin
      strobe_q   <= 1'b0;
    end
  end

  // Count each strobe as it is launched, so the count matches the strobe cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (grant_valid && (sel_req.reg_addr != ZERO_REG) && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.req_ready        = grant;
  assign bus.write_reg        = wb_q.reg_addr;
  assign bus.write_data       = wb_q.data;
  assign bus.signal_reg_write = strobe_q;
  assign bus.grant_id         = grant_id_q;
  assign bus.write_count      = count_q;

endmodule

// File: tb/tb_mips_reg_write_arbiter.sv
// Directed bench for the register-file write arbiter. A second instance with
// a 4-bit counter follows the same stimulus so counter saturation can be seen.
module tb_mips_reg_write_arbiter;

  localparam int NUM_REQ = 2;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mips_reg_write_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(16)) bus ();
  mips_reg_write_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(4))  bus4 ();

  mips_reg_write_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mips_reg_write_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  // The small-counter instance sees exactly the same requests.
  assign bus4.wr_enable = bus.wr_enable;
  assign bus4.req_valid = bus.req_valid;
  assign bus4.req_reg   = bus.req_reg;
  assign bus4.req_data  = bus.req_data;

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one set of request inputs.
  task automatic applyStimulus(input logic en, input logic [1:0] valid,
                               input logic [4:0] r0, input logic [4:0] r1,
                               input logic [31:0] d0, input logic [31:0] d1);
    bus.wr_enable = en;
    bus.req_valid = valid;
    bus.req_reg   = {r1, r0};
    bus.req_data  = {d1, d0};
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    applyStimulus(1'b1, 2'b11, 5'd8, 5'd4, 32'hDEADBEEF, 32'h0);

    // Reset state, with both requesters valid.
    @(posedge clk); #1;
    checkOutput("rst_ready",  bus.req_ready, 2'b00);
    checkOutput("rst_strobe", bus.signal_reg_write, 1'b0);
    checkOutput("rst_reg",    bus.write_reg, 5'd0);
    checkOutput("rst_data",   bus.write_data, 32'h0);
    checkOutput("rst_gid",    bus.grant_id, 2'd0);
    checkOutput("rst_count",  bus.write_count, 16'd0);

    // Release: requester 0 has priority.
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rel_ready", bus.req_ready, 2'b01);

    // Single write from requester 0.
    applyStimulus(1'b1, 2'b01, 5'd8, 5'd4, 32'hDEADBEEF, 32'h0);
    #1;
    checkOutput("single_ready", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    checkOutput("single_strobe", bus.signal_reg_write, 1'b1);
    checkOutput("single_reg",    bus.write_reg, 5'd8);
    checkOutput("single_data",   bus.write_data, 32'hDEADBEEF);
    checkOutput("single_gid",    bus.grant_id, 2'd0);
    checkOutput("single_count",  bus.write_count, 16'd1);

    // Write to $zero from requester 1: accepted, not strobed, not counted.
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 5'd8, 5'd0, 32'h0, 32'h1234);
    #1;
    checkOutput("zero_ready", bus.req_ready, 2'b10);
    @(posedge clk); #1;
    checkOutput("zero_strobe", bus.signal_reg_write, 1'b0);
    checkOutput("zero_count",  bus.write_count, 16'd1);
    checkOutput("zero_gid",    bus.grant_id, 2'd1);
    checkOutput("zero_data",   bus.write_data, 32'h1234);

    // Contention: grants alternate 0,1,... starting at 0, strobe every cycle.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, 2'b11, 5'd3, 5'd4, 32'hA000_0000 + 32'(c), 32'hB000_0000 + 32'(c));
      #1;
      checkOutput("cont_ready", bus.req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      checkOutput("cont_strobe", bus.signal_reg_write, 1'b1);
      checkOutput("cont_reg",    bus.write_reg, (c % 2 == 0) ? 5'd3 : 5'd4);
      checkOutput("cont_data",   bus.write_data,
                  (c % 2 == 0) ? 32'hA000_0000 + 32'(c) : 32'hB000_0000 + 32'(c));
      checkOutput("cont_gid",    bus.grant_id, (c % 2 == 0) ? 2'd0 : 2'd1);
      checkOutput("cont_count",  bus.write_count, 64'(2 + c));
    end

    // Halt: no grants, no strobes, outputs hold.
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b11, 5'd3, 5'd4, 32'h5, 32'h6);
      #1;
      checkOutput("halt_ready", bus.req_ready, 2'b00);
      @(posedge clk); #1;
      checkOutput("halt_strobe", bus.signal_reg_write, 1'b0);
      checkOutput("halt_reg",    bus.write_reg, 5'd4);
      checkOutput("halt_count",  bus.write_count, 16'd7);
    end

    // Resume from the unchanged pointer (requester 0).
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 5'd3, 5'd4, 32'h5, 32'h6);
    #1;
    checkOutput("resume_ready", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    checkOutput("resume_strobe", bus.signal_reg_write, 1'b1);
    checkOutput("resume_reg",    bus.write_reg, 5'd3);
    checkOutput("resume_count",  bus.write_count, 16'd8);

    // A registered write, then reset mid-cycle cancels it immediately.
    @(negedge clk);
    #1;
    checkOutput("pre_rst_ready", bus.req_ready, 2'b10);
    @(posedge clk); #1;
    checkOutput("pre_rst_strobe", bus.signal_reg_write, 1'b1);
    checkOutput("pre_rst_count",  bus.write_count, 16'd9);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_strobe", bus.signal_reg_write, 1'b0);
    checkOutput("mid_rst_reg",    bus.write_reg, 5'd0);
    checkOutput("mid_rst_data",   bus.write_data, 32'h0);
    checkOutput("mid_rst_gid",    bus.grant_id, 2'd0);
    checkOutput("mid_rst_count",  bus.write_count, 16'd0);
    checkOutput("mid_rst_ready",  bus.req_ready, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rerel_ready", bus.req_ready, 2'b01);

    // Saturation: 20 non-zero writes, 4-bit counter sticks at 15.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 2'b01, 5'd9, 5'd4, 32'h100 + 32'(k), 32'h0);
      @(posedge clk); #1;
      checkOutput("sat_count4", bus4.write_count, (k + 1 > 15) ? 64'd15 : 64'(k + 1));
      @(negedge clk);
    end
    checkOutput("sat_count16", bus.write_count, 16'd20);

    // Idle after the burst: no ready, no strobe, data holds.
    applyStimulus(1'b1, 2'b00, 5'd9, 5'd4, 32'h0, 32'h0);
    #1;
    checkOutput("idle_ready", bus.req_ready, 2'b00);
    @(posedge clk); #1;
    checkOutput("idle_strobe", bus.signal_reg_write, 1'b0);
    checkOutput("idle_data",   bus.write_data, 32'h113);
    checkOutput("idle_count4", bus4.write_count, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_reg_write_arbiter.md
Name: mips_reg_write_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback sources, e.g. the ALU result path and the load-return path.
- Each source presents a write request with a valid/ready handshake. The block grants one request per cycle using round-robin order.
- It registers the winner and drives the register file's write_reg, write_data and signal_reg_write inputs, one cycle after acceptance.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..4).
- CNT_W, 16, width of the saturating accepted-write counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- wr_enable  input  1  global permit; when 0, no request is granted (pipeline halt).
- req_valid  input  NUM_REQ  per-requester write request.
- req_reg  input  5*NUM_REQ  destination register; requester i occupies bits [5i+4:5i].
- req_data  input  32*NUM_REQ  write value; requester i occupies bits [32i+31:32i].
- req_ready  output  NUM_REQ  grant, one-hot or zero, combinational.
- write_reg  output  5  registered destination to the register file.
- write_data  output  32  registered data to the register file.
- signal_reg_write  output  1  registered write strobe to the register file.
- grant_id  output  2  registered index of the last accepted requester.
- write_count  output  CNT_W  saturating count of strobes actually issued.

Behaviour:
- Reset (asynchronous, immediate):
  - signal_reg_write=0, write_reg=0, write_data=0, grant_id=0, write_count=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - req_ready is 0 while reset is high.
- Handshake:
  - Transfer on requester i occurs when req_valid[i] and req_ready[i] are both high at a posedge.
  - A requester holds its valid, reg and data stable until it receives ready.
  - Ready never depends on that requester's own data.
- Grant (combinational):
  - If wr_enable=0 or no valid is set, req_ready=0.
  - Otherwise grant the first valid requester, searching from the pointer upward and wrapping modulo NUM_REQ.
  - At most one ready bit is set.
- Pointer update: on a transfer from requester i, the pointer becomes (i+1) mod NUM_REQ. With no transfer, the pointer holds.
- Latency: the cycle after a transfer, write_reg=req_reg[i], write_data=req_data[i], grant_id=i.
- Write strobe:
  - signal_reg_write=1 for exactly one cycle, unless req_reg[i]==0.
  - A write to $zero is accepted (ready given, pointer advances) but issues no strobe and does not count.
- Idle cycles: with no transfer, signal_reg_write=0 next cycle. write_reg and write_data hold their last values.
- Back-to-back transfers: one transfer and one strobe per cycle, sustained with no bubbles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 grants.
- write_count: increments on each issued strobe and saturates at all-ones (no wrap).
- wr_enable:
  - Dropping wr_enable blocks new grants only.
  - A write already registered still strobes the next cycle.
- Reset mid-operation: the pending strobe is cancelled immediately. No write reaches the register file after reset asserts.

Decomposition:
- Shared include mips_defines.vh holds the constants REG_ADDR_W=5, DATA_W=32 and ZERO_REG=5'd0. The register file and this block both use it.
- One natural sub-module, mips_rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: request vector, enable, pointer.
  - Output: one-hot grant plus encoded index.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset: assert reset mid-cycle with req_valid=2'b11 -> all outputs 0 immediately, req_ready=2'b00. Release -> the first grant goes to requester 0.
- Single write: req0 valid, reg=5'd8, data=32'hDEADBEEF -> req_ready=2'b01 that cycle. Next cycle signal_reg_write=1, write_reg=8, write_data=DEADBEEF, grant_id=0, write_count=1.
- Contention: both valid continuously for 6 cycles (req0 reg 3, req1 reg 4) -> grant order 0,1,0,1,0,1. Six consecutive strobes alternating write_reg 3,4. write_count=6.
- $zero write: req1 valid, reg=0, data=32'h1234 -> req_ready[1]=1, no strobe next cycle, write_count unchanged. Pointer advances, so a following both-valid cycle grants requester 0.
- Halt: wr_enable=0 with both valid for 3 cycles -> req_ready=0 and no strobes. Raise wr_enable -> grant resumes from the unchanged pointer.
- Saturation: with CNT_W=4, issue 20 non-zero writes -> write_count stops at 4'hF.
